// File: rtl/risc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : risc_controller
//  Purpose  : 8-phase instruction sequencer and opcode decoder for the 8-bit
//             accumulator CPU; produces memory/PC/IR/accumulator strobes.
//  Revision : 1.0  initial release
// ============================================================================

module risc_controller #(
    parameter int OP_W        = 3,
    parameter bit HALT_FREEZE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic [OP_W-1:0] alu_op,
    output logic [2:0]      phase,
    output logic            sel,
    output logic            rd,
    output logic            ld_ir,
    output logic            inc_pc,
    output logic            ld_pc,
    output logic            ld_ac,
    output logic            wr,
    output logic            data_e,
    output logic            halt
);

    localparam logic [OP_W-1:0] c_op_hlt = OP_W'(0);
    localparam logic [OP_W-1:0] c_op_skz = OP_W'(1);
    localparam logic [OP_W-1:0] c_op_add = OP_W'(2);
    localparam logic [OP_W-1:0] c_op_and = OP_W'(3);
    localparam logic [OP_W-1:0] c_op_xor = OP_W'(4);
    localparam logic [OP_W-1:0] c_op_lda = OP_W'(5);
    localparam logic [OP_W-1:0] c_op_sto = OP_W'(6);
    localparam logic [OP_W-1:0] c_op_jmp = OP_W'(7);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    phase_t r_phase_q;
    phase_t w_phase_d;
    phase_t w_phase_inc;
    logic   r_halt_q;
    logic   w_halt_d;

    logic   w_aluop;
    logic   w_is_hlt;
    logic   w_is_skz;
    logic   w_is_sto;
    logic   w_is_jmp;

    logic   w_sel;
    logic   w_rd;
    logic   w_ld_ir;
    logic   w_inc_pc;
    logic   w_ld_pc;
    logic   w_ld_ac;
    logic   w_wr;
    logic   w_data_e;

    assign w_aluop  = (opcode == c_op_add) || (opcode == c_op_and) ||
                      (opcode == c_op_xor) || (opcode == c_op_lda);
    assign w_is_hlt = (opcode == c_op_hlt);
    assign w_is_skz = (opcode == c_op_skz);
    assign w_is_sto = (opcode == c_op_sto);
    assign w_is_jmp = (opcode == c_op_jmp);

    // Halt is latched at the edge that ends OP_ADDR; once set only reset clears it.
    always_comb begin
        w_halt_d    = r_halt_q | ((r_phase_q == PH_OP_ADDR) && w_is_hlt);
        w_phase_inc = phase_t'(r_phase_q + 3'd1);
    end

    generate
        if (HALT_FREEZE) begin : g_phase_freeze
            always_comb begin
                w_phase_d = w_phase_inc;
                if (w_halt_d) begin
                    w_phase_d = PH_OP_ADDR;
                end
            end
        end else begin : g_phase_free
            always_comb begin
                w_phase_d = w_phase_inc;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase_q <= PH_INST_ADDR;
            r_halt_q  <= 1'b0;
        end else begin
            r_phase_q <= w_phase_d;
            r_halt_q  <= w_halt_d;
        end
    end

    always_comb begin
        w_sel    = 1'b0;
        w_rd     = 1'b0;
        w_ld_ir  = 1'b0;
        w_inc_pc = 1'b0;
        w_ld_pc  = 1'b0;
        w_ld_ac  = 1'b0;
        w_wr     = 1'b0;
        w_data_e = 1'b0;
        case (r_phase_q)
            PH_INST_ADDR: begin
                w_sel = 1'b1;
            end
            PH_INST_FETCH: begin
                w_sel = 1'b1;
                w_rd  = 1'b1;
            end
            PH_INST_LOAD: begin
                w_sel   = 1'b1;
                w_rd    = 1'b1;
                w_ld_ir = 1'b1;
            end
            PH_IDLE: begin
                w_sel   = 1'b1;
                w_ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
                w_inc_pc = !w_is_hlt;
            end
            PH_OP_FETCH: begin
                w_rd = w_aluop;
            end
            PH_ALU_OP: begin
                // zero is only meaningful here, where the alu result is settled
                w_rd     = w_aluop;
                w_inc_pc = w_is_skz && zero;
                w_ld_pc  = w_is_jmp;
                w_data_e = w_is_sto;
            end
            PH_STORE: begin
                w_rd     = w_aluop;
                w_ld_ac  = w_aluop;
                w_ld_pc  = w_is_jmp;
                w_data_e = w_is_sto;
                w_wr     = w_is_sto;
            end
            default: begin
                w_sel = 1'b0;
            end
        endcase
        if (r_halt_q) begin
            w_sel    = 1'b0;
            w_rd     = 1'b0;
            w_ld_ir  = 1'b0;
            w_inc_pc = 1'b0;
            w_ld_pc  = 1'b0;
            w_ld_ac  = 1'b0;
            w_wr     = 1'b0;
            w_data_e = 1'b0;
        end
    end

    assign alu_op = opcode;
    assign phase  = r_phase_q;
    assign halt   = r_halt_q;
    assign sel    = w_sel;
    assign rd     = w_rd;
    assign ld_ir  = w_ld_ir;
    assign inc_pc = w_inc_pc;
    assign ld_pc  = w_ld_pc;
    assign ld_ac  = w_ld_ac;
    assign wr     = w_wr;
    assign data_e = w_data_e;

endmodule

`default_nettype wire

// File: tb/tb_risc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_risc_controller
//  Purpose  : Directed self-checking bench for risc_controller.
//  Revision : 1.0  initial release
// ============================================================================

module tb_risc_controller;

    logic       clk;
    logic       reset;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] alu_op;
    logic [2:0] phase;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [7:0] strobes;

    int checks = 0;
    int errors = 0;

    // Strobe vector order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e}
    assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e};

    risc_controller #(
        .OP_W        (3),
        .HALT_FREEZE (1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .opcode (opcode),
        .zero   (zero),
        .alu_op (alu_op),
        .phase  (phase),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_decode(input logic [2:0] p, input logic [2:0] op,
                                              input logic z);
        logic aluop;
        logic [7:0] v;
        aluop = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        v[7] = (p <= 3'd3);
        v[6] = (p == 3'd1) || (p == 3'd2) || ((p >= 3'd5) && aluop);
        v[5] = (p == 3'd2) || (p == 3'd3);
        v[4] = ((p == 3'd4) && (op != 3'd0)) || ((p == 3'd6) && (op == 3'd1) && z);
        v[3] = (p >= 3'd6) && (op == 3'd7);
        v[2] = (p == 3'd7) && aluop;
        v[1] = (p == 3'd7) && (op == 3'd6);
        v[0] = (p >= 3'd6) && (op == 3'd6);
        return v;
    endfunction

    task automatic test_reset();
        logic [2:0] op;
        reset  = 1'b1;
        opcode = 3'd0;
        zero   = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if (phase !== 3'd0) begin
            errors++;
            $display("FAIL reset_phase: got %0d expected 0", phase);
        end
        checks++;
        if (halt !== 1'b0) begin
            errors++;
            $display("FAIL reset_halt: got %b expected 0", halt);
        end
        checks++;
        if (strobes !== 8'h80) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 10000000", strobes);
        end
        for (int i = 0; i < 8; i++) begin
            op     = 3'(i);
            opcode = op;
            #1;
            checks++;
            if (alu_op !== op) begin
                errors++;
                $display("FAIL alu_op_pass op%0d: got %0d expected %0d", i, alu_op, op);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_add();
        logic [7:0] exp [8];
        exp    = '{8'h80, 8'hC0, 8'hE0, 8'hA0, 8'h10, 8'h40, 8'h40, 8'h44};
        opcode = 3'd2;
        zero   = 1'b0;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            checks++;
            if (phase !== 3'(p)) begin
                errors++;
                $display("FAIL add_phase p%0d: got %0d expected %0d", p, phase, p);
            end
            checks++;
            if (strobes !== exp[p]) begin
                errors++;
                $display("FAIL add_strobes p%0d: got %b expected %b", p, strobes, exp[p]);
            end
            step();
        end
        checks++;
        if (phase !== 3'd0) begin
            errors++;
            $display("FAIL add_wrap: got %0d expected 0", phase);
        end
    endtask

    task automatic test_sto();
        logic [7:0] exp [8];
        exp    = '{8'h80, 8'hC0, 8'hE0, 8'hA0, 8'h10, 8'h00, 8'h01, 8'h03};
        opcode = 3'd6;
        zero   = 1'b1;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            checks++;
            if (strobes !== exp[p] || phase !== 3'(p)) begin
                errors++;
                $display("FAIL sto_strobes p%0d: got phase %0d %b expected phase %0d %b",
                         p, phase, strobes, p, exp[p]);
            end
            step();
        end
    endtask

    task automatic test_skz();
        logic [7:0] exp1 [8];
        logic [7:0] exp0 [8];
        exp1   = '{8'h80, 8'hC0, 8'hE0, 8'hA0, 8'h10, 8'h00, 8'h10, 8'h00};
        exp0   = '{8'h80, 8'hC0, 8'hE0, 8'hA0, 8'h10, 8'h00, 8'h00, 8'h00};
        opcode = 3'd1;
        zero   = 1'b1;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            checks++;
            if (strobes !== exp1[p] || phase !== 3'(p)) begin
                errors++;
                $display("FAIL skz_z1 p%0d: got phase %0d %b expected phase %0d %b",
                         p, phase, strobes, p, exp1[p]);
            end
            step();
        end
        zero = 1'b0;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            checks++;
            if (strobes !== exp0[p] || phase !== 3'(p)) begin
                errors++;
                $display("FAIL skz_z0 p%0d: got phase %0d %b expected phase %0d %b",
                         p, phase, strobes, p, exp0[p]);
            end
            step();
        end
    endtask

    task automatic test_jmp();
        logic [7:0] exp [8];
        exp    = '{8'h80, 8'hC0, 8'hE0, 8'hA0, 8'h10, 8'h00, 8'h08, 8'h08};
        opcode = 3'd7;
        zero   = 1'b1;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            checks++;
            if (strobes !== exp[p] || phase !== 3'(p)) begin
                errors++;
                $display("FAIL jmp_strobes p%0d: got phase %0d %b expected phase %0d %b",
                         p, phase, strobes, p, exp[p]);
            end
            step();
        end
    endtask

    task automatic test_hlt();
        logic [7:0] exp [5];
        exp    = '{8'h80, 8'hC0, 8'hE0, 8'hA0, 8'h00};
        opcode = 3'd0;
        zero   = 1'b0;
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            checks++;
            if (strobes !== exp[p] || phase !== 3'(p) || halt !== 1'b0) begin
                errors++;
                $display("FAIL hlt_pre p%0d: got phase %0d halt %b %b expected phase %0d halt 0 %b",
                         p, phase, halt, strobes, p, exp[p]);
            end
            step();
        end
        // Opcode moves away from HLT; the halted state must not care.
        opcode = 3'd2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (phase !== 3'd4 || halt !== 1'b1 || strobes !== 8'h00) begin
                errors++;
                $display("FAIL hlt_hold c%0d: got phase %0d halt %b %b expected phase 4 halt 1 00000000",
                         i, phase, halt, strobes);
            end
            step();
        end
        reset = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (phase !== 3'd0 || halt !== 1'b0 || strobes !== 8'h80) begin
            errors++;
            $display("FAIL hlt_reset: got phase %0d halt %b %b expected phase 0 halt 0 10000000",
                     phase, halt, strobes);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        opcode = 3'd6;
        zero   = 1'b0;
        for (int p = 0; p < 6; p++) begin
            step();
        end
        @(negedge clk);
        checks++;
        if (phase !== 3'd6 || strobes !== 8'h01) begin
            errors++;
            $display("FAIL mid_pre: got phase %0d %b expected phase 6 00000001", phase, strobes);
        end
        reset = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (phase !== 3'd0 || halt !== 1'b0 || strobes !== 8'h80) begin
            errors++;
            $display("FAIL mid_reset: got phase %0d halt %b %b expected phase 0 halt 0 10000000",
                     phase, halt, strobes);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] exp_phase;
        logic [7:0] exp_v;
        int         bad;
        exp_phase = 3'd0;
        bad       = 0;
        for (int i = 0; i < 50; i++) begin
            opcode = 3'($urandom_range(7, 1));
            zero   = 1'($urandom_range(1, 0));
            @(negedge clk);
            exp_v = ref_decode(exp_phase, opcode, zero);
            checks++;
            if (phase !== exp_phase || halt !== 1'b0 || strobes !== exp_v || alu_op !== opcode) begin
                errors++;
                bad++;
                $display("FAIL random c%0d: got phase %0d halt %b %b alu_op %0d expected phase %0d halt 0 %b alu_op %0d",
                         i, phase, halt, strobes, alu_op, exp_phase, exp_v, opcode);
            end
            step();
            exp_phase = exp_phase + 3'd1;
        end
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 3'd0;
        zero   = 1'b0;
        test_reset();
        test_add();
        test_sto();
        test_skz();
        test_jmp();
        test_hlt();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
